// File: rtl/coreaxi4dma_ctrl_if_arbiter_if.sv
// rtl/coreaxi4dma_ctrl_if_arbiter_if.sv - requester/register-bus signal bundle for the control-interface arbiter
//
// Groups the two requester channels, the shared response, and the control
// register bus.
//   slave  : arbiter side (takes requests, drives the register bus)
//   master : environment side (requesters plus the register mux/banks)
interface coreaxi4dma_ctrl_if_arbiter_if;
  // requester 0 (host AXI4-Lite bridge)
  logic        req0_valid;
  logic        req0_wr;
  logic [10:0] req0_addr;
  logic [31:0] req0_wdata;
  logic [3:0]  req0_strb;
  logic        req0_ready;
  logic        req0_done;
  // requester 1 (descriptor/stream control engine)
  logic        req1_valid;
  logic        req1_wr;
  logic [10:0] req1_addr;
  logic [31:0] req1_wdata;
  logic [3:0]  req1_strb;
  logic        req1_ready;
  logic        req1_done;
  // shared response, qualified by reqN_done
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // control register bus
  logic        ctrl_rd;
  logic        ctrl_wr;
  logic [10:0] ctrl_addr;
  logic [31:0] ctrl_wdata;
  logic [3:0]  ctrl_strb;
  logic [31:0] ctrl_rdata;
  logic        ctrl_rdvalid;
  logic        ctrl_wrrdy;

  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata, req0_strb,
    input  req1_valid, req1_wr, req1_addr, req1_wdata, req1_strb,
    input  ctrl_rdata, ctrl_rdvalid, ctrl_wrrdy,
    output req0_ready, req0_done, req1_ready, req1_done,
    output rsp_rdata, rsp_err,
    output ctrl_rd, ctrl_wr, ctrl_addr, ctrl_wdata, ctrl_strb
  );

  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata, req0_strb,
    output req1_valid, req1_wr, req1_addr, req1_wdata, req1_strb,
    output ctrl_rdata, ctrl_rdvalid, ctrl_wrrdy,
    input  req0_ready, req0_done, req1_ready, req1_done,
    input  rsp_rdata, rsp_err,
    input  ctrl_rd, ctrl_wr, ctrl_addr, ctrl_wdata, ctrl_strb
  );
endinterface

// File: rtl/coreaxi4dma_ctrl_if_arbiter.sv
// rtl/coreaxi4dma_ctrl_if_arbiter.sv - round-robin arbiter and access sequencer for the 11-bit control-register bus
//
// Ports:
//   CLOCK  : system clock, rising edge
//   RESETN : asynchronous active-low reset
//   bus    : slave modport of coreaxi4dma_ctrl_if_arbiter_if (two requesters,
//            shared response, control register bus)
// One access at a time: IDLE (arbitrate/accept) -> ACCESS (strobe held until
// ready/valid or timeout) -> RESP (one-cycle done to the owner) -> IDLE.
module coreaxi4dma_ctrl_if_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input logic                           CLOCK,
  input logic                           RESETN,
  coreaxi4dma_ctrl_if_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
  // Last ACCESS cycle index before abort; unused when the timeout is disabled.
  localparam logic [7:0] TO_LAST = 8'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;      // requester that wins a tie
  logic        gnt_q, gnt_d;      // owner of the current access
  logic        wr_q, wr_d;
  logic [10:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic any_valid;
  logic gnt_sel;
  logic complete;
  logic timeout;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  // Tie goes to the pointer; otherwise the only valid requester.
  assign gnt_sel   = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;
  // Only the ready of the access type in flight counts.
  assign complete  = wr_q ? bus.ctrl_wrrdy : bus.ctrl_rdvalid;
  assign timeout   = TO_EN && (cnt_q == TO_LAST) && !complete;

  // State register
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_ACCESS;
          gnt_d   = gnt_sel;
          ptr_d   = ~gnt_sel;
          wr_d    = gnt_sel ? bus.req1_wr    : bus.req0_wr;
          addr_d  = gnt_sel ? bus.req1_addr  : bus.req0_addr;
          wdata_d = gnt_sel ? bus.req1_wdata : bus.req0_wdata;
          strb_d  = gnt_sel ? bus.req1_strb  : bus.req0_strb;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        if (complete) begin
          // Writes carry no read data back; report zero.
          state_d = ST_RESP;
          rdata_d = wr_q ? 32'h0 : bus.ctrl_rdata;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = ST_RESP;
          rdata_d = wr_q ? 32'h0 : ERR_RDATA;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic; strobes derive from the async-reset state so they drop at once on reset.
  always_comb begin
    bus.req0_ready = (state_q == ST_IDLE) && any_valid && !gnt_sel;
    bus.req1_ready = (state_q == ST_IDLE) && any_valid &&  gnt_sel;
    bus.req0_done  = (state_q == ST_RESP) && !gnt_q;
    bus.req1_done  = (state_q == ST_RESP) &&  gnt_q;
    bus.ctrl_rd    = (state_q == ST_ACCESS) && !wr_q;
    bus.ctrl_wr    = (state_q == ST_ACCESS) &&  wr_q;
    bus.ctrl_addr  = addr_q;
    bus.ctrl_wdata = wdata_q;
    bus.ctrl_strb  = strb_q;
    bus.rsp_rdata  = rdata_q;
    bus.rsp_err    = err_q;
  end

endmodule

// File: doc/coreaxi4dma_ctrl_if_arbiter.md
Name: coreaxi4dma_ctrl_if_arbiter

Overview:
- Round-robin arbiter and access sequencer for the shared 11-bit control-register bus feeding the control-interface read mux.
- Two requesters share the bus: requester 0 is the host AXI4-Lite slave bridge; requester 1 is the internal descriptor/stream control engine.
- Runs one access at a time: drives strobe, address and data, waits for the bank's ready/valid, and returns read data or a timeout error to the owning requester.

Parameters:
TIMEOUT_CYCLES, 255, ACCESS-state cycles before an access is aborted with error; 0 disables the timeout; legal range 0..255.
ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out access.

Ports:
CLOCK  in  1  system clock; all logic rising-edge.
RESETN  in  1  asynchronous active-low reset.
req0_valid, req1_valid  in  1 each  access request, level; may drop before acceptance.
req0_wr, req1_wr  in  1 each  1 = write, 0 = read.
req0_addr, req1_addr  in  11 each  register byte address.
req0_wdata, req1_wdata  in  32 each  write data.
req0_strb, req1_strb  in  4 each  write byte enables.
req0_ready, req1_ready  out  1 each  one-cycle accept pulse.
req0_done, req1_done  out  1 each  one-cycle completion pulse.
rsp_rdata  out  32  read data; valid with reqN_done.
rsp_err  out  1  timeout flag; valid with reqN_done.
ctrl_rd  out  1  read strobe to the register mux.
ctrl_wr  out  1  write strobe to the register banks.
ctrl_addr  out  11  registered access address.
ctrl_wdata  out  32  registered write data.
ctrl_strb  out  4  registered byte enables.
ctrl_rdata  in  32  read data from the mux.
ctrl_rdvalid  in  1  read data valid from the mux.
ctrl_wrrdy  in  1  write accepted from the mux.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, priority pointer selects req0.
- All outputs reset to 0: ready, done, rsp_rdata, rsp_err, ctrl_rd, ctrl_wr, ctrl_addr, ctrl_wdata, ctrl_strb. Timeout counter resets to 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE arbitration:
  - Any valid: grant = highest-priority valid requester. reqN_ready is asserted combinationally that cycle.
  - Register addr/wdata/strb/wr and grant id; go to ACCESS.
  - Pointer then favours the non-granted requester. Both valid -> the requester not served last wins. After reset, req0 wins a tie.
- ACCESS:
  - ctrl_wr (if wr) or ctrl_rd (if rd) held high continuously. ctrl_addr/wdata/strb stable for the whole state.
  - Completion: write when ctrl_wrrdy = 1 sampled; read when ctrl_rdvalid = 1 sampled, with ctrl_rdata captured into rsp_rdata and rsp_err = 0.
  - Strobe deasserts on the clock edge following completion; go to RESP.
  - Counter increments each ACCESS cycle. With TIMEOUT_CYCLES != 0, if counter == TIMEOUT_CYCLES-1 and no completion: strobes drop, rsp_err = 1, rsp_rdata = ERR_RDATA (reads) or 0 (writes), go to RESP.
  - Completion and timeout in the same cycle: completion wins. Counter clears on leaving ACCESS.
- RESP: done pulse to the granted requester only, one cycle. rsp_rdata/rsp_err hold until the next RESP. Go to IDLE.
- Latency: accept at cycle T, strobe from T+1. Completion sampled at T+k (k >= 1) gives done at T+k+1. Next accept no earlier than T+k+2, so no back-to-back overlap.
- ctrl_wrrdy/ctrl_rdvalid are ignored outside ACCESS, and the opposite-type ready is ignored inside ACCESS.
- A requester dropping valid after acceptance does not abort the access; done is still issued.
- Never both ready pulses, both done pulses, or both ctrl_rd and ctrl_wr in one cycle.
- RESETN asserted mid-access: strobes drop immediately and asynchronously, no done is issued, and the access is lost.

Test Plan:
- Single read: req0 read 0x460, bank returns ctrl_rdvalid=1 with 0x1234_5678 two cycles after strobe -> ctrl_rd high 3 cycles; req0_done with rsp_rdata=0x1234_5678, rsp_err=0.
- Tie, round-robin: req0 and req1 both continuously request writes (req0 to 0x060, req1 to 0x004), ctrl_wrrdy=1 -> grants alternate req0, req1, req0, req1; ctrl_addr alternates 0x060/0x004; a new access starts every 3 cycles.
- Timeout: TIMEOUT_CYCLES=4, req1 reads 0x070, bank never responds -> ctrl_rd high exactly 4 cycles; req1_done with rsp_err=1, rsp_rdata=0xDEAD_BEEF.
- Boundary race: TIMEOUT_CYCLES=4, ctrl_rdvalid asserted in the 4th ACCESS cycle -> rsp_err=0, real data returned.
- Reset mid-access: RESETN low during ACCESS of a write to 0x000 -> ctrl_wr drops without a clock edge; no done; after release req0 wins the next tie.
- Disabled timeout: TIMEOUT_CYCLES=0, bank stalls 300 cycles -> strobe held 300 cycles, then normal completion with rsp_err=0.
